// File: rtl/bcd_stopwatch_counter.sv
// Two-digit BCD stopwatch: prescales clk into count ticks and runs a 00-99 seconds counter
// with edge-triggered start/stop and clear controls plus tick/wrap status strobes.
module bcd_stopwatch_counter #(
  parameter int TICK_CYCLES = 10_000_000,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  output logic [7:0] num,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PRESCALE_LAST = CNT_W'(TICK_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic             ss_prev;
  logic             clr_prev;
  logic             ss_rise;
  logic             clr_rise;
  logic [CNT_W-1:0] prescale;
  logic [CNT_W-1:0] prescale_next;
  logic [3:0]       tens;
  logic [3:0]       units;
  logic [3:0]       tens_next;
  logic [3:0]       units_next;
  logic             tick_next;
  logic             wrap_next;

  assign num      = {tens, units};
  assign ss_rise  = start_stop & ~ss_prev;
  assign clr_rise = clear & ~clr_prev;

  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_prev  <= 1'b0;
      clr_prev <= 1'b0;
    end else begin
      ss_prev  <= start_stop;
      clr_prev <= clear;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Clear takes priority over start/stop in every state.
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    if (clr_rise) begin
      state_next = IDLE;
    end else if (ss_rise) begin
      unique case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Counting depends on the current state, so an increment landing on the
  // RUN->PAUSE edge still completes; a pause simply freezes the held phase.
  always_comb begin
    prescale_next = prescale;
    tens_next     = tens;
    units_next    = units;
    tick_next     = 1'b0;
    wrap_next     = 1'b0;
    if (clr_rise) begin
      prescale_next = '0;
      tens_next     = 4'd0;
      units_next    = 4'd0;
    end else if (state == RUN) begin
      if (prescale == PRESCALE_LAST) begin
        prescale_next = '0;
        tick_next     = 1'b1;
        if (units != 4'd9) begin
          units_next = units + 4'd1;
        end else begin
          units_next = 4'd0;
          if (tens != 4'd9) begin
            tens_next = tens + 4'd1;
          end else begin
            tens_next = 4'd0;
            wrap_next = 1'b1;
          end
        end
      end else begin
        prescale_next = prescale + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
      tens     <= 4'd0;
      units    <= 4'd0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      running  <= 1'b0;
    end else begin
      prescale <= prescale_next;
      tens     <= tens_next;
      units    <= units_next;
      tick     <= tick_next;
      wrap     <= wrap_next;
      running  <= (state == RUN);
    end
  end

endmodule

// File: doc/bcd_stopwatch_counter.md
Name: bcd_stopwatch_counter

Overview:
Sequential producer of the packed two-digit BCD value consumed by the seven-segment digit decoder. Prescales the system clock into count ticks and runs a 00–99 BCD seconds counter. Provides start/stop and clear control with rising-edge detection, plus status strobes for the top level. Output num[7:4] is tens and num[3:0] is units, always valid BCD (0–9 per nibble).

Parameters:
TICK_CYCLES, 10_000_000, clk cycles per count increment (1 s at 10 MHz); legal range ≥2
CNT_W, 24, prescaler width; must satisfy 2^CNT_W ≥ TICK_CYCLES

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start_stop  input  1  level input, already synchronized/debounced; rising edge toggles run/pause
clear  input  1  level input, already synchronized/debounced; rising edge clears count and stops
num  output  8  packed BCD count: [7:4] tens, [3:0] units
running  output  1  high while in RUN state
tick  output  1  one-cycle pulse, high in the cycle num shows a newly incremented value
wrap  output  1  one-cycle pulse, high in the cycle num shows 00 after 99

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at a clk edge): state=IDLE, num=8'h00, prescaler=0, running=0, tick=0, wrap=0, edge-detect history regs=0. Reset overrides all other inputs, including mid-count.
- Edge detect: ss_prev/clr_prev register the inputs every cycle. ss_rise = start_stop & ~ss_prev; clr_rise = clear & ~clr_prev. Holding an input high produces exactly one event.
- States: IDLE (count 00, stopped), RUN, PAUSE.
  - IDLE: ss_rise -> RUN. clr_rise -> IDLE (no-op).
  - RUN: ss_rise -> PAUSE. clr_rise -> IDLE.
  - PAUSE: ss_rise -> RUN. clr_rise -> IDLE.
  - clr_rise and ss_rise in the same cycle: clear wins and the next state is IDLE.
- Transition latency: the state changes at the same clk edge where the input is first sampled high. running reflects the new state in the following cycle. running = (state==RUN), registered.
- Clear action: at the edge taking the block to IDLE, num <= 00 and prescaler <= 0. tick and wrap are not asserted.
- Prescaler advances only in RUN.
  - Prescaler counts 0..TICK_CYCLES-1. At the edge where it equals TICK_CYCLES-1, it returns to 0 and num increments.
  - In PAUSE the prescaler and num hold. Resume continues from the held phase; no prescaler reset.
  - From IDLE, the first increment occurs TICK_CYCLES cycles after the edge entering RUN.
- BCD increment rules:
  - units<9: units+1.
  - units==9: units=0 and tens+1.
  - tens==9 && units==9: num=00, and counting continues in RUN.
- tick: registered, high for exactly the one cycle in which the incremented num is first visible.
- wrap: same timing as tick, only on the 99->00 increment.
- Increment vs ss_rise in the same cycle (RUN -> PAUSE): the increment still takes effect and tick pulses; the state then holds in PAUSE.
- Increment vs clr_rise in the same cycle: clear wins. num=00, no tick, no wrap.
- num never holds a non-BCD nibble.

Test Plan:
- Reset: assert rst 2 cycles mid-RUN at num=8'h37 -> next cycle num=00, running=0, tick=0, wrap=0. With rst held, a start_stop pulse has no effect.
- Start/count (TICK_CYCLES=4): ss_rise at edge E0 -> running=1 at E0+1; num=01 with tick=1 at E0+4; num=02 at E0+8. start_stop held high 20 cycles gives exactly one toggle.
- BCD carry/wrap: run from 00 -> sequence 08, 09, 10 (nibble 0xA never seen). 98, 99, 00 with wrap=1 for one cycle only at 99->00, then 01, still running.
- Pause/resume phase: pause 2 cycles after a tick (prescaler=2), hold 10 cycles -> num constant, no tick. Resume -> next tick after 2 cycles, not 4.
- Clear priority: in RUN at num=45, pulse clear and start_stop in the same cycle -> num=00, state IDLE, running=0. Clear landing on an increment cycle -> num=00, tick=0.
- Clear from PAUSE at num=12 -> num=00, IDLE. A subsequent ss_rise restarts with the first tick TICK_CYCLES later.
